// File: rtl/exe_wb_buffer_pkg.sv
// exe_wb_buffer: shared writeback packet types and widths
// used by the execute lane, writeback and bypass network.
package exe_wb_buffer_pkg;

    localparam int SIZE_DATA         = 32;
    localparam int SIZE_PHYSICAL_LOG = 7;
    localparam int SIZE_AL_LOG       = 4;

    typedef struct packed {
        logic executed;
        logic destValid;
        logic exception;
        logic mispredict;
    } exeFlgs;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_AL_LOG-1:0]       alID;
        exeFlgs                       flags;
        logic [SIZE_PHYSICAL_LOG-1:0] phyDest;
        logic [SIZE_DATA-1:0]         destData;
    } wbPkt;

    typedef struct packed {
        logic                         valid;
        logic [SIZE_PHYSICAL_LOG-1:0] tag;
        logic [SIZE_DATA-1:0]         data;
    } bypassPkt;

endpackage

// File: rtl/exe_wb_buffer_if.sv
// exe_wb_buffer: execute-to-writeback handshake bundle.
// slave = the buffer, master = the lane/writeback side.
interface exe_wb_buffer_if;
    import exe_wb_buffer_pkg::*;

    wbPkt     exePacket_i;
    logic     exeReady_o;
    wbPkt     wbPacket_o;
    logic     wbReady_i;
    bypassPkt bypassPacket_o;

    modport slave (
        input  exePacket_i,
        input  wbReady_i,
        output exeReady_o,
        output wbPacket_o,
        output bypassPacket_o
    );

    modport master (
        output exePacket_i,
        output wbReady_i,
        input  exeReady_o,
        input  wbPacket_o,
        input  bypassPacket_o
    );

endinterface

// File: rtl/exe_wb_buffer_ctrl.sv
// exe_wb_buffer_ctrl: occupancy state, ready/enqueue/dequeue
// decisions, flush handling and the saturating stall counter.
module exe_wb_buffer_ctrl #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             recover,
    input  logic             in_valid,
    input  logic             wb_ready,
    output logic [1:0]       count,
    output logic             exe_ready,
    output logic             enq,
    output logic             deq,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    occ_e state;
    occ_e state_nxt;
    logic stall_inc;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= EMPTY;
        else       state <= state_nxt;
    end

    // Ready depends only on registered occupancy and the flush,
    // never on wb_ready.
    always_comb begin
        exe_ready = (state != FULL) && !recover;
        enq       = in_valid && exe_ready;
        deq       = (state != EMPTY) && wb_ready && !recover;
        state_nxt = state;
        unique case (1'b1)
            recover:      state_nxt = EMPTY;
            enq && !deq:  state_nxt = (state == EMPTY) ? ONE : FULL;
            deq && !enq:  state_nxt = (state == FULL) ? ONE : EMPTY;
            default:      state_nxt = state;
        endcase
    end

    assign count     = state;
    assign stall_inc = in_valid && !exe_ready && !recover;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_count <= '0;
        else if (stall_inc && !(&stall_count))
            stall_count <= stall_count + 1'b1;
    end

endmodule

// File: rtl/exe_wb_buffer.sv
// exe_wb_buffer: two-entry in-order skid buffer, ALU lane to writeback.
// Define EXE_WB_BYPASS_EN to drive bypassPacket_o from the head entry.
module exe_wb_buffer
    import exe_wb_buffer_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              recoverFlag_i,
    exe_wb_buffer_if.slave    bus,
    output logic [CNT_W-1:0]  stallCount_o
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [CW-1:0] count;
    logic          enq;
    logic          deq;
    wbPkt          entry0;
    wbPkt          entry1;
    wbPkt          entry0_nxt;
    wbPkt          entry1_nxt;

    exe_wb_buffer_ctrl #(
        .CNT_W (CNT_W)
    ) u_ctrl (
        .clk         (clk),
        .reset       (reset),
        .recover     (recoverFlag_i),
        .in_valid    (bus.exePacket_i.valid),
        .wb_ready    (bus.wbReady_i),
        .count       (count),
        .exe_ready   (bus.exeReady_o),
        .enq         (enq),
        .deq         (deq),
        .stall_count (stallCount_o)
    );

    // Vacated slots are zeroed so an empty head reads as all-zero.
    always_comb begin
        entry0_nxt = entry0;
        entry1_nxt = entry1;
        unique case (1'b1)
            recoverFlag_i: begin
                entry0_nxt = '0;
                entry1_nxt = '0;
            end
            enq && deq: begin
                entry0_nxt = bus.exePacket_i;
            end
            deq && !enq: begin
                entry0_nxt = entry1;
                entry1_nxt = '0;
            end
            enq && !deq && (count == '0): begin
                entry0_nxt = bus.exePacket_i;
            end
            enq && !deq && (count != '0): begin
                entry1_nxt = bus.exePacket_i;
            end
            default: begin
                entry0_nxt = entry0;
                entry1_nxt = entry1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            entry0 <= '0;
            entry1 <= '0;
        end else begin
            entry0 <= entry0_nxt;
            entry1 <= entry1_nxt;
        end
    end

    assign bus.wbPacket_o = entry0;

`ifdef EXE_WB_BYPASS_EN
    always_comb begin
        bus.bypassPacket_o = '0;
        if (entry0.valid && entry0.flags.destValid) begin
            bus.bypassPacket_o.valid = 1'b1;
            bus.bypassPacket_o.tag   = entry0.phyDest;
            bus.bypassPacket_o.data  = entry0.destData;
        end
    end
`else
    assign bus.bypassPacket_o = '0;
`endif

endmodule
